uart_rx_fifo: RTL and testbench

// - Parametrised UART receiver for the loco_top host link; replaces the fixed 8N1 115200 front end.
// - Oversamples rx and validates the start bit at mid-bit, then shifts in DATA_BITS LSB-first.
// - Checks STOP_BITS stop bits, and parity when compiled in.
// - Buffers received words in a FIFO_DEPTH-entry FIFO with a valid/ready interface to the encoder input.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a small output FIFO.
// The frame is start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Optional feature macro: UART_PARITY_EN. When it is defined, a parity bit is
// checked (PARITY_ODD selects odd parity) and parity_err is live. When it is
// undefined, the parity logic is absent and parity_err is tied low.
// Handshake: rx_data/rx_valid show the FIFO head. A word is consumed on every
// clock edge where rx_valid & rx_ready are both high. rx_data is only
// meaningful while rx_valid is high.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state;
    logic                 s1, rs;
    logic [1:0]           fill;
    logic                 armed;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           stop_cnt;
    logic                 stop_ok;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;

    // Mid-bit sample strobe and FIFO control.
    logic sample, leaving, full, pop, do_push;
    assign sample   = (cnt == HALF);
    assign leaving  = (state == STOP) && stop_ok;
    assign full     = (level == LW'(FIFO_DEPTH));
    assign pop      = rx_valid && rx_ready;
    assign do_push  = leaving && !par_bad && (!full || pop);

    assign rx_data    = mem[rd_ptr];
    assign rx_valid   = (level != '0);
    assign fifo_level = level;
    assign busy       = (state != IDLE);

    // Two-flop synchroniser; armed goes high once the line has been seen
    // idle after reset, so a line held low through reset starts nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            rs    <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= rx;
            rs    <= s1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & rs);
        end
    end

    // Receive FSM: bit timing, data shift, stop check and frame_err pulse.
    // The bit counter free-runs through a frame, so after the start bit is
    // confirmed at mid-bit every later sample also lands at mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            stop_ok   <= 1'b0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == IDLE) cnt <= '0;
            else               cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (armed && !rs) state <= START;
                START: if (sample) begin
                    if (rs) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: if (sample) begin
                    shreg <= {rs, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                        stop_cnt <= '0;
                        stop_ok  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: if (sample) state <= STOP;
`endif
                STOP: begin
                    if (stop_ok) begin
                        stop_ok <= 1'b0;
                        state   <= IDLE;
                    end else if (sample) begin
                        if (!rs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else if (stop_cnt == 2'(STOP_BITS - 1)) begin
                            stop_ok <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end
                end
                BREAK: if (rs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_PARITY_EN
    logic par_err_q;
    assign parity_err = par_err_q;

    // Latch the parity verdict at the parity sample; pulse it when the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= leaving && par_bad;
            if (state == PARITY && sample)
                par_bad <= ((^shreg) ^ rs) != (PARITY_ODD != 0);
        end
    end
`else
    logic unused_parity;
    assign unused_parity = (PARITY_ODD != 0);
    assign par_bad       = 1'b0;
    assign parity_err    = 1'b0;
`endif

    // FIFO storage, pointers and occupancy; overrun when a good word meets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= leaving && !par_bad && full && !pop;
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames and keeps an expected-word
// queue plus expected error counts derived from the frame contents.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CPB    = 16;
`ifdef UART_PARITY_EN
    localparam int DW     = 7;
`else
    localparam int DW     = 8;
`endif
    localparam int SB     = 1;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int BIT_NS = CPB * 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [LW-1:0] fifo_level;
    logic          busy, frame_err, overrun, parity_err;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];
    int n_pop = 0, n_fe = 0, n_ovr = 0, n_pe = 0, valid_cycles = 0;
    int exp_fe = 0, exp_ovr = 0, exp_pe = 0;
    int ready_mode = 0;   // 0 = low, 1 = high, 2 = random

    // Clock and reset
    always #10 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_level(fifo_level), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    // rx_ready driver, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every pop is checked against the expected queue; pulses are counted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (frame_err) n_fe++;
            if (overrun) n_ovr++;
            if (parity_err) n_pe++;
            if (rx_valid && rx_ready) begin
                n_pop++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got %h, expected no word", rx_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        miscompares++;
                        $display("FAIL pop_data: got %h, expected %h", rx_data, e);
                    end
                end
            end
        end
    end

    // Driver: one serial frame; the model decides the frame's fate before the stop bit.
    // rx is left at the stop-bit level on return.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_good, input bit par_flip);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ par_flip;
        #(BIT_NS);
`endif
        if (!stop_good)                exp_fe++;
        else if (par_flip)             exp_pe++;
        else if (exp_q.size() >= DEPTH) exp_ovr++;
        else                           exp_q.push_back(d);
        rx = stop_good;
        #(BIT_NS * SB);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (rx_data !== '0) begin miscompares++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        vectors++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_pulses: got %b want 000", {frame_err, overrun, parity_err});
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int p0, v0, f0;
        ready_mode = 1;
        #(BIT_NS);
        p0 = n_pop; v0 = valid_cycles; f0 = n_fe;
        send_frame(DW'(8'hA5), 1'b1, 1'b0);
        #(2 * BIT_NS);
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL single_pops: got %0d want 1", n_pop - p0); end
        vectors++; if (valid_cycles - v0 != 1) begin miscompares++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cycles - v0); end
        vectors++; if (n_fe != f0) begin miscompares++; $display("FAIL single_frame_err: got %0d want 0", n_fe - f0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b2b [5];
        int o0, p0;
        b2b = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01};
        ready_mode = 0;
        #(BIT_NS);
        o0 = n_ovr;
        for (int i = 0; i < 5; i++) send_frame(DW'(b2b[i]), 1'b1, 1'b0);
        #(BIT_NS);
        vectors++; if (fifo_level !== LW'(DEPTH)) begin miscompares++; $display("FAIL b2b_level: got %0d want %0d", fifo_level, DEPTH); end
        vectors++; if (n_ovr - o0 != 1) begin miscompares++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr - o0); end
        vectors++; if (n_ovr != exp_ovr) begin miscompares++; $display("FAIL b2b_overrun_model: got %0d want %0d", n_ovr, exp_ovr); end
        p0 = n_pop;
        ready_mode = 1;
        repeat (10) @(posedge clk);
        #3;
        vectors++; if (n_pop - p0 != 4) begin miscompares++; $display("FAIL b2b_pops: got %0d want 4", n_pop - p0); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL b2b_drained: got %0d want 0", fifo_level); end
    endtask

    task automatic test_frame_err();
        int f0, p0;
        ready_mode = 1;
        f0 = n_fe;
        send_frame(DW'(8'h3C), 1'b0, 1'b0);
        #(BIT_NS);
        vectors++; if (n_fe - f0 != 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d want 1", n_fe - f0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL ferr_no_push: got %0d want 0", fifo_level); end
        rx = 1'b1;
        #(BIT_NS);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_exit_break: got %b want 0", busy); end
        p0 = n_pop;
        send_frame(DW'(8'h42), 1'b1, 1'b0);
        #(2 * BIT_NS);
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL ferr_recover: got %0d want 1", n_pop - p0); end
    endtask

    task automatic test_glitch();
        int f0, p0;
        ready_mode = 1;
        f0 = n_fe; p0 = n_pop;
        rx = 1'b0;
        #100;
        rx = 1'b1;
        #(2 * BIT_NS);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b want 0", busy); end
        vectors++; if (n_pop != p0 || fifo_level !== '0) begin
            miscompares++; $display("FAIL glitch_push: got %0d pops level %0d want 0 0", n_pop - p0, fifo_level);
        end
        vectors++; if (n_fe != f0) begin miscompares++; $display("FAIL glitch_err: got %0d want 0", n_fe - f0); end
        send_frame(DW'(8'h81), 1'b1, 1'b0);
        #(2 * BIT_NS);
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL glitch_next_frame: got %0d want 1", n_pop - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        ready_mode = 1;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin rx = 1'b1; #(BIT_NS); end
        rx = 1'b0;
        #(BIT_NS / 2);
        rst_n = 1'b0;
        exp_q.delete();
        #200;
        rst_n = 1'b1;
        #(2 * BIT_NS);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_low_line_busy: got %b want 0", busy); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
        rx = 1'b1;
        #(BIT_NS);
        p0 = n_pop;
        send_frame(DW'(8'h7E), 1'b1, 1'b0);
        #(2 * BIT_NS);
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL rstmid_pops: got %0d want 1", n_pop - p0); end
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int n = 0; n < 12; n++) begin
            logic [DW-1:0] d;
            bit sg, pf;
            d  = DW'($urandom);
            sg = ($urandom_range(0, 3) != 0);
            pf = 1'b0;
`ifdef UART_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
`endif
            send_frame(d, sg, pf);
            rx = 1'b1;
            if (sg) #(BIT_NS * $urandom_range(0, 2));
            else    #(BIT_NS * $urandom_range(1, 2));
        end
        ready_mode = 1;
        #(2 * BIT_NS);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_left_words: got %0d want 0", exp_q.size()); end
        vectors++; if (n_fe != exp_fe) begin miscompares++; $display("FAIL rand_frame_err: got %0d want %0d", n_fe, exp_fe); end
        vectors++; if (n_ovr != exp_ovr) begin miscompares++; $display("FAIL rand_overrun: got %0d want %0d", n_ovr, exp_ovr); end
        vectors++; if (n_pe != exp_pe) begin miscompares++; $display("FAIL rand_parity_err: got %0d want %0d", n_pe, exp_pe); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL rand_level: got %0d want 0", fifo_level); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int p0, e0;
        ready_mode = 1;
        p0 = n_pop; e0 = n_pe;
        send_frame(7'h41, 1'b1, 1'b0);
        #(2 * BIT_NS);
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL parity_good_pops: got %0d want 1", n_pop - p0); end
        send_frame(7'h41, 1'b1, 1'b1);
        #(2 * BIT_NS);
        vectors++; if (n_pe - e0 != 1) begin miscompares++; $display("FAIL parity_err_pulse: got %0d want 1", n_pe - e0); end
        vectors++; if (n_pop - p0 != 1) begin miscompares++; $display("FAIL parity_bad_pushed: got %0d want 1", n_pop - p0); end
    endtask
`endif

    initial begin
        @(posedge clk);
        #3;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
